// File: rtl/comm_pkg.sv
// Shared definitions for the UART receive path: FSM states, oversampling constants
// and a 2-of-3 majority helper used by the bit sampler.
package comm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rxState_t;

  localparam int OVERSAMPLE    = 16;
  localparam int SAMPLE_TICK_A = 7;
  localparam int SAMPLE_TICK_B = 8;
  localparam int SAMPLE_TICK_C = 9;
  localparam int DATA_BITS     = 8;
  localparam int SYNC_STAGES   = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with synchronous flush. The head is read straight from
// a shallow LUT-RAM array so a word pushed on one edge is visible right after it.
module sync_fifo #(
  parameter int DataWidth_Gen = 8,
  parameter int DepthLog2_Gen = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     flush,
  input  logic                     pushEn,
  input  logic [DataWidth_Gen-1:0] pushData,
  input  logic                     popEn,
  output logic [DataWidth_Gen-1:0] headData,
  output logic                     headVal,
  output logic                     full
);

  localparam int DEPTH = 2 ** DepthLog2_Gen;
  localparam logic [DepthLog2_Gen:0] PTR_ONE = 1;

  logic [DataWidth_Gen-1:0] memArray [DEPTH];
  logic [DepthLog2_Gen:0]   wrPtrReg;
  logic [DepthLog2_Gen:0]   rdPtrReg;
  logic                     empty;
  logic                     popAccept;
  logic                     pushAccept;

  assign empty = (wrPtrReg == rdPtrReg);
  assign full  = (wrPtrReg[DepthLog2_Gen] != rdPtrReg[DepthLog2_Gen]) &&
                 (wrPtrReg[DepthLog2_Gen-1:0] == rdPtrReg[DepthLog2_Gen-1:0]);

  assign popAccept  = popEn && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pushAccept = pushEn && (!full || popAccept);

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      if (pushAccept) wrPtrReg <= wrPtrReg + PTR_ONE;
      if (popAccept)  rdPtrReg <= rdPtrReg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst && !flush && pushAccept) begin
      memArray[wrPtrReg[DepthLog2_Gen-1:0]] <= pushData;
    end
  end

  assign headData = memArray[rdPtrReg[DepthLog2_Gen-1:0]];
  assign headVal  = !empty;

endmodule

// File: rtl/uart_rx_oversampler.sv
// 16x oversampled 8-bit UART receiver with majority voting, FIFO buffering and sticky
// framing/overrun flags. Define UART_RX_PARITY_EN to add a parity bit and ParityErr flag.
module uart_rx_oversampler
  import comm_pkg::*;
#(
  parameter int OversampleDiv_Gen = 27,
  parameter int FifoDepthLog2_Gen = 4
) (
  input  logic       SysClk_ClkIn,
  input  logic       SysRst_RstIn,
  input  logic       Enable_EnaIn,
  input  logic       UartRx_DatIn,
  output logic [7:0] RxData_DatOut,
  output logic       RxData_ValOut,
  input  logic       RxData_RdyIn,
  output logic       FramingErr_DatOut,
  output logic       Overrun_DatOut,
  input  logic       ErrClr_EnaIn,
`ifdef UART_RX_PARITY_EN
  input  logic       Parity_OddIn,
  output logic       ParityErr_DatOut,
`endif
  output logic       Irq_DatOut
);

  localparam logic [15:0] DIV_LAST  = 16'(OversampleDiv_Gen - 1);
  localparam logic [3:0]  TICK_A    = 4'(SAMPLE_TICK_A);
  localparam logic [3:0]  TICK_B    = 4'(SAMPLE_TICK_B);
  localparam logic [3:0]  TICK_C    = 4'(SAMPLE_TICK_C);
  localparam logic [3:0]  TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   rxLine;
  logic                   lineDlyReg;
  logic                   fallEdge;

  rxState_t               stateReg;
  rxState_t               stateNext;
  logic [15:0]            divCntReg;
  logic [3:0]             tickCntReg;
  logic [2:0]             bitIdxReg;
  logic [DATA_BITS-1:0]   shiftReg;
  logic                   sampleAReg;
  logic                   sampleBReg;

  logic                   tick;
  logic                   atTick9;
  logic                   atTick15;
  logic                   voteBit;

  logic                   shiftEn;
  logic                   pushReq;
  logic                   setFraming;
  logic                   setOverrun;
  logic                   dropByte;

  logic                   fifoFull;
  logic                   canPush;
  logic                   popReq;
  logic [7:0]             headData;
  logic                   headVal;

  logic                   framingReg;
  logic                   overrunReg;

`ifdef UART_RX_PARITY_EN
  logic                   setParity;
  logic                   expParity;
  logic                   parityBadReg;
  logic                   parityErrReg;
`endif

  // Line synchronizer keeps running while disabled so a line already low at enable
  // is not mistaken for a start bit.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge SysClk_ClkIn) begin
          if (SysRst_RstIn) syncReg[gi] <= 1'b1;
          else              syncReg[gi] <= UartRx_DatIn;
        end
      end else begin : g_rest
        always_ff @(posedge SysClk_ClkIn) begin
          if (SysRst_RstIn) syncReg[gi] <= 1'b1;
          else              syncReg[gi] <= syncReg[gi-1];
        end
      end
    end
  endgenerate

  assign rxLine   = syncReg[SYNC_STAGES-1];
  assign fallEdge = lineDlyReg & ~rxLine;

  assign tick     = (stateReg != StIdle) && (divCntReg == DIV_LAST);
  assign atTick9  = tick && (tickCntReg == TICK_C);
  assign atTick15 = tick && (tickCntReg == TICK_LAST);
  assign voteBit  = majority3(sampleAReg, sampleBReg, rxLine);

  assign popReq  = headVal && RxData_RdyIn;
  assign canPush = !fifoFull || popReq;

  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) stateReg <= StIdle;
    else              stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    if (!Enable_EnaIn) begin
      stateNext = StIdle;
    end else begin
      case (stateReg)
        StIdle: begin
          if (fallEdge) stateNext = StStart;
        end
        StStart: begin
          if (atTick9 && voteBit) stateNext = StIdle;
          else if (atTick15)      stateNext = StData;
        end
        StData: begin
          if (atTick15 && bitIdxReg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            stateNext = StParity;
`else
            stateNext = StStop;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (atTick15) stateNext = StStop;
        end
`endif
        // Leave at tick 9 so a back-to-back start edge is not missed.
        StStop: begin
          if (atTick9) stateNext = StIdle;
        end
        default: stateNext = StIdle;
      endcase
    end
  end

  always_comb begin
    shiftEn    = 1'b0;
    pushReq    = 1'b0;
    setFraming = 1'b0;
    setOverrun = 1'b0;
`ifdef UART_RX_PARITY_EN
    setParity  = 1'b0;
`endif
    if (Enable_EnaIn) begin
      case (stateReg)
        StData: shiftEn = atTick9;
`ifdef UART_RX_PARITY_EN
        StParity: setParity = atTick9 && (voteBit != expParity);
`endif
        StStop: begin
          if (atTick9) begin
            if (!voteBit) begin
              setFraming = 1'b1;
            end else if (!dropByte) begin
              if (canPush) pushReq    = 1'b1;
              else         setOverrun = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      lineDlyReg <= 1'b1;
      divCntReg  <= '0;
      tickCntReg <= '0;
      bitIdxReg  <= '0;
      shiftReg   <= '0;
      sampleAReg <= 1'b0;
      sampleBReg <= 1'b0;
    end else begin
      lineDlyReg <= rxLine;
      // Counters sit at zero in Idle, so every frame restarts the divider cleanly.
      if (stateReg == StIdle || stateNext == StIdle) begin
        divCntReg  <= '0;
        tickCntReg <= '0;
        bitIdxReg  <= '0;
        shiftReg   <= '0;
      end else begin
        divCntReg <= tick ? 16'd0 : divCntReg + 16'd1;
        if (tick) tickCntReg <= tickCntReg + 4'd1;
        if (tick && tickCntReg == TICK_A) sampleAReg <= rxLine;
        if (tick && tickCntReg == TICK_B) sampleBReg <= rxLine;
        if (shiftEn) shiftReg <= {voteBit, shiftReg[DATA_BITS-1:1]};
        if (stateReg == StData && atTick15) bitIdxReg <= bitIdxReg + 3'd1;
      end
    end
  end

  // Setting a flag wins over a clear arriving in the same cycle.
  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      framingReg <= 1'b0;
      overrunReg <= 1'b0;
    end else begin
      if (setFraming)        framingReg <= 1'b1;
      else if (ErrClr_EnaIn) framingReg <= 1'b0;
      if (setOverrun)        overrunReg <= 1'b1;
      else if (ErrClr_EnaIn) overrunReg <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign expParity = (^shiftReg) ^ Parity_OddIn;
  assign dropByte  = parityBadReg;

  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      parityBadReg <= 1'b0;
      parityErrReg <= 1'b0;
    end else begin
      if (stateReg == StIdle) parityBadReg <= 1'b0;
      else if (setParity)     parityBadReg <= 1'b1;
      if (setParity)         parityErrReg <= 1'b1;
      else if (ErrClr_EnaIn) parityErrReg <= 1'b0;
    end
  end

  assign ParityErr_DatOut = parityErrReg;
`else
  assign dropByte = 1'b0;
`endif

  sync_fifo #(
    .DataWidth_Gen(DATA_BITS),
    .DepthLog2_Gen(FifoDepthLog2_Gen)
  ) u_fifo (
    .clk     (SysClk_ClkIn),
    .srst    (SysRst_RstIn),
    .flush   (!Enable_EnaIn),
    .pushEn  (pushReq),
    .pushData(shiftReg),
    .popEn   (RxData_RdyIn),
    .headData(headData),
    .headVal (headVal),
    .full    (fifoFull)
  );

  assign RxData_DatOut     = headVal ? headData : 8'h00;
  assign RxData_ValOut     = headVal;
  assign FramingErr_DatOut = framingReg;
  assign Overrun_DatOut    = overrunReg;

`ifdef UART_RX_PARITY_EN
  assign Irq_DatOut = headVal | framingReg | overrunReg | parityErrReg;
`else
  assign Irq_DatOut = headVal | framingReg | overrunReg;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: drives whole frames on the serial line and
// checks FIFO contents, error flags, interrupt and receive latency.
`timescale 1ns/1ps
module tb_uart_rx_oversampler;

  localparam int DIV      = 4;
  localparam int BIT_CLKS = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Edge detect lands 3 clocks after the start bit; stop-bit tick 9 is global tick
  // 16*(FRAME_BITS-1)+9, which fires (index+1)*DIV clocks after that.
  localparam int VAL_LATENCY = 3 + (16 * (FRAME_BITS - 1) + 10) * DIV;

  logic       clk = 1'b0;
  logic       srst;
  logic       enable;
  logic       rxLine;
  logic       rdy;
  logic       errClr;
  logic [7:0] rxData;
  logic       rxVal;
  logic       framingErr;
  logic       overrun;
  logic       irq;
`ifdef UART_RX_PARITY_EN
  logic       parityOdd;
  logic       parityErr;
`endif

  int         testsRun    = 0;
  int         testsFailed = 0;
  int         cycleCnt    = 0;
  int         startCycle;
  int         riseCycle;
  logic [7:0] popped;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  uart_rx_oversampler #(
    .OversampleDiv_Gen(DIV),
    .FifoDepthLog2_Gen(4)
  ) dut (
    .SysClk_ClkIn     (clk),
    .SysRst_RstIn     (srst),
    .Enable_EnaIn     (enable),
    .UartRx_DatIn     (rxLine),
    .RxData_DatOut    (rxData),
    .RxData_ValOut    (rxVal),
    .RxData_RdyIn     (rdy),
    .FramingErr_DatOut(framingErr),
    .Overrun_DatOut   (overrun),
    .ErrClr_EnaIn     (errClr),
`ifdef UART_RX_PARITY_EN
    .Parity_OddIn     (parityOdd),
    .ParityErr_DatOut (parityErr),
`endif
    .Irq_DatOut       (irq)
  );

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic evenPar(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic sendFrame(input logic [7:0] data, input logic parBit, input logic stopBit);
    logic [FRAME_BITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stopBit, parBit, data, 1'b0};
`else
    bits = {stopBit, data, 1'b0};
`endif
    $display("[TB] frame data=0x%02h par=%0b stop=%0b", data, parBit, stopBit);
    for (int i = 0; i < FRAME_BITS; i++) begin
      rxLine = bits[i];
      waitClks(BIT_CLKS);
    end
    rxLine = 1'b1;
  endtask

  task automatic popByte(output logic [7:0] d);
    d   = rxData;
    rdy = 1'b1;
    waitClks(1);
    rdy = 1'b0;
    $display("[TB] pop 0x%02h", d);
  endtask

  task automatic pulseErrClr();
    errClr = 1'b1;
    waitClks(1);
    errClr = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    srst   = 1'b1;
    enable = 1'b1;
    rxLine = 1'b1;
    rdy    = 1'b0;
    errClr = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityOdd = 1'b0;
`endif
    waitClks(5);
    checkVal("rst_val",     32'(rxVal),      32'd0);
    checkVal("rst_data",    32'(rxData),     32'd0);
    checkVal("rst_framing", 32'(framingErr), 32'd0);
    checkVal("rst_overrun", 32'(overrun),    32'd0);
    checkVal("rst_irq",     32'(irq),        32'd0);
    srst = 1'b0;
    waitClks(5);

    // Single byte with exact latency
    startCycle = cycleCnt;
    riseCycle  = -1;
    fork
      sendFrame(8'hA5, evenPar(8'hA5), 1'b1);
      begin
        for (int n = 0; n < 4 * VAL_LATENCY && !rxVal; n++) @(negedge clk);
        riseCycle = cycleCnt;
      end
    join
    checkVal("a5_latency", 32'(riseCycle - startCycle), 32'(VAL_LATENCY));
    checkVal("a5_val",     32'(rxVal),      32'd1);
    checkVal("a5_data",    32'(rxData),     32'hA5);
    checkVal("a5_framing", 32'(framingErr), 32'd0);
    checkVal("a5_irq",     32'(irq),        32'd1);
    popByte(popped);
    checkVal("a5_val_after_pop", 32'(rxVal), 32'd0);
    checkVal("a5_irq_after_pop", 32'(irq),   32'd0);

    // Short low glitch must be rejected
    rxLine = 1'b0;
    waitClks(5 * DIV);
    rxLine = 1'b1;
    waitClks(12 * BIT_CLKS);
    checkVal("glitch_val",     32'(rxVal),      32'd0);
    checkVal("glitch_framing", 32'(framingErr), 32'd0);
    checkVal("glitch_overrun", 32'(overrun),    32'd0);

    // 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) sendFrame(8'(i), evenPar(8'(i)), 1'b1);
    checkVal("ovr_flag",    32'(overrun),    32'd1);
    checkVal("ovr_framing", 32'(framingErr), 32'd0);
    checkVal("ovr_val",     32'(rxVal),      32'd1);
    for (int i = 0; i < 16; i++) begin
      popByte(popped);
      checkVal($sformatf("ovr_pop%0d", i), 32'(popped), 32'(i));
    end
    checkVal("ovr_empty",     32'(rxVal),   32'd0);
    checkVal("ovr_irq_stick", 32'(irq),     32'd1);
    pulseErrClr();
    checkVal("ovr_cleared",   32'(overrun), 32'd0);
    checkVal("ovr_irq_clear", 32'(irq),     32'd0);

    // Stop bit low, then a good frame
    sendFrame(8'h3C, evenPar(8'h3C), 1'b0);
    waitClks(2 * BIT_CLKS);
    checkVal("frm_val",  32'(rxVal),      32'd0);
    checkVal("frm_flag", 32'(framingErr), 32'd1);
    checkVal("frm_irq",  32'(irq),        32'd1);
    sendFrame(8'h3C, evenPar(8'h3C), 1'b1);
    checkVal("frm_next_val",  32'(rxVal),  32'd1);
    checkVal("frm_next_data", 32'(rxData), 32'h3C);
    popByte(popped);
    pulseErrClr();
    checkVal("frm_cleared", 32'(framingErr), 32'd0);

    // Enable dropped mid-frame flushes the queue
    sendFrame(8'h11, evenPar(8'h11), 1'b1);
    sendFrame(8'h22, evenPar(8'h22), 1'b1);
    sendFrame(8'h33, evenPar(8'h33), 1'b1);
    checkVal("ena_queued", 32'(rxVal), 32'd1);
    fork
      sendFrame(8'h99, evenPar(8'h99), 1'b1);
      begin
        waitClks(5 * BIT_CLKS + 8 * DIV);
        enable = 1'b0;
        waitClks(1);
        checkVal("ena_flush_val",  32'(rxVal),  32'd0);
        checkVal("ena_flush_data", 32'(rxData), 32'd0);
      end
    join
    waitClks(BIT_CLKS);
    enable = 1'b1;
    waitClks(4);
    sendFrame(8'h55, evenPar(8'h55), 1'b1);
    checkVal("ena_55_val",  32'(rxVal),  32'd1);
    checkVal("ena_55_data", 32'(rxData), 32'h55);
    popByte(popped);
    checkVal("ena_only_entry", 32'(rxVal),      32'd0);
    checkVal("ena_no_framing", 32'(framingErr), 32'd0);
    checkVal("ena_no_overrun", 32'(overrun),    32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1
    sendFrame(8'h07, 1'b0, 1'b1);
    checkVal("par_bad_flag", 32'(parityErr), 32'd1);
    checkVal("par_bad_val",  32'(rxVal),     32'd0);
    checkVal("par_bad_irq",  32'(irq),       32'd1);
    sendFrame(8'h07, 1'b1, 1'b1);
    checkVal("par_ok_val",  32'(rxVal),  32'd1);
    checkVal("par_ok_data", 32'(rxData), 32'h07);
    popByte(popped);
    pulseErrClr();
    checkVal("par_cleared", 32'(parityErr), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampler.md
Name: uart_rx_oversampler

Overview:
- 8-bit UART receiver; consumes the UART receive line that the communication selector routes from the shared Rx/SDA pin in UART mode.
- 16x oversampled, majority-voted, buffers received bytes in a small FIFO.
- Reports framing/overrun errors and raises a level interrupt; this interrupt feeds the selector's UART IRQ input.

Parameters:
- OversampleDiv_Gen, 27, system clocks per 1/16 bit (50 MHz / 115200 / 16 ≈ 27); legal range 2..65535.
- FifoDepthLog2_Gen, 4, FIFO depth = 2**FifoDepthLog2_Gen bytes (16).

Ports:
- SysClk_ClkIn  in  1  system clock.
- SysRst_RstIn  in  1  reset, synchronous, active-high.
- Enable_EnaIn  in  1  1 = receiver active; 0 = held idle and FIFO flushed (driven by UART mode select).
- UartRx_DatIn  in  1  asynchronous serial line, idle high.
- RxData_DatOut  out  8  FIFO head byte, valid while RxData_ValOut = 1.
- RxData_ValOut  out  1  FIFO not empty.
- RxData_RdyIn  in  1  pop FIFO head when Val & Rdy.
- FramingErr_DatOut  out  1  sticky; stop bit sampled low.
- Overrun_DatOut  out  1  sticky; byte completed while FIFO full.
- ErrClr_EnaIn  in  1  one-cycle pulse clears both sticky flags.
- Irq_DatOut  out  1  level: RxData_ValOut | FramingErr | Overrun.

Behaviour:
- Reset values: all outputs 0; FSM Idle; divider, tick and bit counters 0; FIFO empty; synchronizer flops reset to 1.
- Input conditioning:
  - 2-flop synchronizer on UartRx_DatIn, reset to 1.
  - Tick pulse every OversampleDiv_Gen clocks. The divider runs only outside Idle and restarts at 0 on the Idle→Start transition.
- Sampling:
  - Each bit spans 16 ticks.
  - Bit value = majority of the synchronized line at ticks 7, 8 and 9.
  - Decision is taken at tick 9.
- FSM:
  - Idle: on a falling edge of the synchronized line (previous 1, current 0) → Start, tick count 0.
  - Start: at tick 9, majority 1 → Idle (glitch rejected, no error); majority 0 → continue. At tick 15 → Data, bit index 0.
  - Data: at tick 9, shift the majority value in LSB-first. At tick 15, increment bit index; after bit 7 → Parity if the optional feature is compiled in, else Stop.
  - Parity (optional feature only): see Optional Feature.
  - Stop: at tick 9, evaluate the stop bit.
    - Stop 1 and FIFO not full → push byte.
    - Stop 1 and FIFO full → drop byte, set Overrun.
    - Stop 0 → drop byte, set FramingErr.
    - Then → Idle immediately (at tick 9, not 15), so back-to-back frames are not missed.
- Latency: byte visible on RxData_ValOut 1 clock after the stop-bit tick-9 decision.
- FIFO:
  - First-word-fall-through; pointers are FifoDepthLog2_Gen+1 bits wide; full when MSBs differ and the rest are equal.
  - Simultaneous push and pop when full: pop takes effect first and the push is accepted (no overrun).
  - Simultaneous push and pop when empty: push accepted, Val rises the next cycle.
- Sticky flags:
  - Set has priority over ErrClr_EnaIn in the same cycle.
  - Flags are not cleared by Enable_EnaIn falling.
- Enable_EnaIn = 0 (including mid-frame):
  - Next cycle: FSM → Idle, partial byte discarded, FIFO pointers reset (flush), RxData_ValOut = 0.
  - Synchronizer keeps running, so a line already low when Enable_EnaIn rises is not taken as a start bit.
- Line held low (break) past stop: one FramingErr, then the FSM waits in Idle for a high→low edge; no repeated pushes.
- Reset mid-frame: identical to the reset state on the next cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds input Parity_OddIn (1 = odd, 0 = even), output ParityErr_DatOut (sticky, cleared by ErrClr_EnaIn) and the Parity state.
  - Parity bit is sampled like a data bit.
  - On mismatch the byte is dropped and ParityErr is set, but the FSM still proceeds to Stop.
  - ParityErr is ORed into Irq_DatOut.
- Undefined: 8N1 only; no extra ports; frame length 10 bits.

Decomposition:
- Shared package (comm_pkg):
  - FSM state enum (Idle, Start, Data, Parity, Stop).
  - Constant OVERSAMPLE = 16 and sample tick indices 7/8/9.
  - Constant DATA_BITS = 8.
- Sub-module: sync_fifo (parameterized width/depth, FWFT, flush input), reusable by a future UART transmitter.

Test Plan:
- Frame 0xA5, 8N1, OversampleDiv_Gen=4 → RxData_DatOut=0xA5, Val=1 1 clk after stop tick 9; FramingErr=0; Irq=1 until popped.
- Low glitch of 5 ticks on an idle line → FSM returns to Idle, no push, no error flags.
- 17 consecutive bytes 0x00..0x10 with Rdy=0 → FIFO holds 0x00..0x0F, Overrun=1; pop sequence returns 0x00..0x0F; ErrClr pulse → Overrun=0.
- Frame 0x3C with stop bit driven 0 → no push, FramingErr=1, Irq=1; a following valid 0x3C is received normally.
- Enable_EnaIn dropped at data bit 4 with 3 bytes queued → Val=0 next clk; after re-enable, frame 0x55 is received as the only entry.
- (UART_RX_PARITY_EN, Parity_OddIn=0) frame 0x07 with parity bit 0 → ParityErr=1, no push; with parity bit 1 → 0x07 pushed.
